// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  // Downstream pipeline-register update coding (00/11 mean hold).
  localparam logic [1:0]  UPD_ADVANCE = 2'b01;
  localparam logic [1:0]  UPD_FLUSH   = 2'b10;

  // Instruction presented when nothing real is available.
  localparam logic [31:0] NOP_INST    = 32'h0000_0001;

  // Sequential fetch increment in bytes.
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer: parks the presented instruction while downstream stalls.
// Clear has priority over load; the payload resets to a bubble so it is never X.
module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        hold_v,
  output logic [31:0] hold_pc,
  output logic [31:0] hold_inst
);

  // Capture {pc, inst} on load, drop the entry on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v    <= 1'b0;
      hold_pc   <= 32'h0;
      hold_inst <= NOP_INST;
    end else if (clear) begin
      hold_v    <= 1'b0;
    end else if (load) begin
      hold_v    <= 1'b1;
      hold_pc   <= load_pc;
      hold_inst <= load_inst;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// BRAM and presents {f_pc, f_inst, f_valid} to the fetch/decode register.
//
// Handshake: the presented instruction is consumed on a clock edge where
// f_valid=1 and update==01; update==10 discards it; any other update value
// keeps it presented unchanged. A redirect pulse overrides everything.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         update,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        f_pc,
  output logic [31:0]        f_inst,
  output logic               f_valid
);

  fetch_state_t state;
  logic [31:0]  pc_q;
  logic         rsp_v;
  logic [31:0]  rsp_pc;

  logic         hold_v;
  logic [31:0]  hold_pc;
  logic [31:0]  hold_inst;
  logic         hold_load;
  logic         hold_clear;

  logic         adv;
  logic         flush;
  logic         issue;

  assign adv   = (update == UPD_ADVANCE);
  assign flush = (update == UPD_FLUSH);

  // Presented source: hold buffer first, then the landing BRAM read, else a bubble.
  always_comb begin
    f_valid = 1'b0;
    f_pc    = 32'h0;
    f_inst  = NOP_INST;
    if (hold_v) begin
      f_valid = 1'b1;
      f_pc    = hold_pc;
      f_inst  = hold_inst;
    end else if (rsp_v) begin
      f_valid = 1'b1;
      f_pc    = rsp_pc;
      f_inst  = imem_rdata;
    end
  end

  // Issue a new read when running and the presentation slot frees up this edge.
  // A flush refetches from a corrected pc_q next cycle, so it never issues.
  assign issue     = ~rst & (state == RUN) & ~redirect & ~flush & (~f_valid | adv);
  assign imem_en   = issue;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  // Park a landing read that is not consumed; drop the entry on consume/flush/redirect.
  assign hold_load  = ~redirect & ~flush & rsp_v & ~hold_v & ~adv;
  assign hold_clear = redirect | flush | (hold_v & adv);

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_pc   (rsp_pc),
    .load_inst (imem_rdata),
    .hold_v    (hold_v),
    .hold_pc   (hold_pc),
    .hold_inst (hold_inst)
  );

  // PC and in-flight read tracking; redirect beats flush beats normal issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rsp_v  <= 1'b0;
      rsp_pc <= 32'h0;
    end else if (redirect) begin
      pc_q   <= redirect_pc;
      rsp_v  <= 1'b0;
    end else if (flush) begin
      if (f_valid) begin
        pc_q <= f_pc;
      end
      rsp_v  <= 1'b0;
    end else if (issue) begin
      rsp_v  <= 1'b1;
      rsp_pc <= pc_q;
      pc_q   <= pc_q + PC_STEP;
    end else begin
      rsp_v  <= 1'b0;
    end
  end

  // RUN/HALTED follows the halt level; halting only gates new issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (halt)  state <= HALTED;
        HALTED:  if (!halt) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 1-cycle BRAM whose word
// at byte address A reads as {16'hBEEF, A[15:0]}.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  update = 2'b01;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] f_pc;
  logic [31:0] f_inst;
  logic        f_valid;

  int vectors = 0;
  int miscompares = 0;

  // Clock: 10 time-unit period; inputs change and outputs are checked off the rising edge.
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
    .clk         (clk),
    .rst         (rst),
    .update      (update),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .f_pc        (f_pc),
    .f_inst      (f_inst),
    .f_valid     (f_valid)
  );

  // Synchronous BRAM model, data valid the cycle after imem_en.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= {16'hBEEF, imem_addr, 2'b00};
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; update = 2'b01;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL rst_en: got %b want 0", imem_en); end
      vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", f_valid); end
    end
    vectors++; if (f_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", f_pc); end
    vectors++; if (f_inst !== 32'h1) begin miscompares++; $display("FAIL rst_inst: got %h want 1", f_inst); end
    cyc(); rst = 1'b0; #1;
    vectors++; if (imem_en !== 1'b1) begin miscompares++; $display("FAIL first_en: got %b want 1", imem_en); end
    vectors++; if (imem_addr !== 14'h0) begin miscompares++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL first_valid: got %b want 0", f_valid); end
  endtask

  task automatic test_back_to_back();
    cyc(); #1;
    vectors++; if (f_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_v0: got %b want 1", f_valid); end
    vectors++; if (f_pc !== 32'h0) begin miscompares++; $display("FAIL b2b_pc0: got %h want 0", f_pc); end
    vectors++; if (f_inst !== 32'hBEEF_0000) begin miscompares++; $display("FAIL b2b_inst0: got %h want beef0000", f_inst); end
    vectors++; if (imem_addr !== 14'h1) begin miscompares++; $display("FAIL b2b_addr1: got %h want 1", imem_addr); end
    cyc(); #1;
    vectors++; if (f_pc !== 32'h4 || f_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_pc4: got %h/%b want 4/1", f_pc, f_valid); end
    vectors++; if (f_inst !== 32'hBEEF_0004) begin miscompares++; $display("FAIL b2b_inst4: got %h want beef0004", f_inst); end
  endtask

  task automatic test_stall();
    cyc(); update = 2'b00; #1;
    vectors++; if (f_pc !== 32'h8) begin miscompares++; $display("FAIL stall_pc_first: got %h want 8", f_pc); end
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL stall_en_first: got %b want 0", imem_en); end
    for (int i = 0; i < 2; i++) begin
      cyc(); #1;
      vectors++; if (f_pc !== 32'h8 || f_valid !== 1'b1) begin miscompares++; $display("FAIL stall_pc: got %h/%b want 8/1", f_pc, f_valid); end
      vectors++; if (f_inst !== 32'hBEEF_0008) begin miscompares++; $display("FAIL stall_inst: got %h want beef0008", f_inst); end
      vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL stall_en: got %b want 0", imem_en); end
    end
    cyc(); update = 2'b01; #1;
    vectors++; if (f_pc !== 32'h8) begin miscompares++; $display("FAIL release_pc: got %h want 8", f_pc); end
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 14'h3) begin miscompares++; $display("FAIL release_issue: got %b/%h want 1/3", imem_en, imem_addr); end
    cyc(); #1;
    vectors++; if (f_pc !== 32'hC || f_valid !== 1'b1) begin miscompares++; $display("FAIL release_next: got %h/%b want c/1", f_pc, f_valid); end
    vectors++; if (f_inst !== 32'hBEEF_000C) begin miscompares++; $display("FAIL release_inst: got %h want beef000c", f_inst); end
  endtask

  task automatic test_redirect();
    cyc(); #1;
    vectors++; if (f_pc !== 32'h10) begin miscompares++; $display("FAIL redir_at: got %h want 10", f_pc); end
    redirect = 1'b1; redirect_pc = 32'h40; update = 2'b10;
    cyc(); redirect = 1'b0; update = 2'b01; #1;
    vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL redir_bubble: got %b want 0", f_valid); end
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 14'h10) begin miscompares++; $display("FAIL redir_issue: got %b/%h want 1/10", imem_en, imem_addr); end
    cyc(); #1;
    vectors++; if (f_pc !== 32'h40 || f_valid !== 1'b1) begin miscompares++; $display("FAIL redir_target: got %h/%b want 40/1", f_pc, f_valid); end
    vectors++; if (f_inst !== 32'hBEEF_0040) begin miscompares++; $display("FAIL redir_inst: got %h want beef0040", f_inst); end
  endtask

  task automatic test_redirect_vs_advance();
    cyc(); redirect = 1'b1; redirect_pc = 32'h18; update = 2'b01; #1;
    vectors++; if (f_pc !== 32'h44) begin miscompares++; $display("FAIL rva_at: got %h want 44", f_pc); end
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL rva_noissue: got %b want 0", imem_en); end
    cyc(); redirect = 1'b0; #1;
    vectors++; if (f_valid !== 1'b0 || imem_addr !== 14'h6) begin miscompares++; $display("FAIL rva_bubble: got %b/%h want 0/6", f_valid, imem_addr); end
    cyc(); #1;
    vectors++; if (f_pc !== 32'h18 || f_valid !== 1'b1) begin miscompares++; $display("FAIL rva_target: got %h/%b want 18/1", f_pc, f_valid); end
  endtask

  task automatic test_flush();
    cyc(); #1;
    vectors++; if (f_pc !== 32'h1C) begin miscompares++; $display("FAIL flush_pre: got %h want 1c", f_pc); end
    cyc(); update = 2'b10; #1;
    vectors++; if (f_pc !== 32'h20 || f_valid !== 1'b1) begin miscompares++; $display("FAIL flush_at: got %h/%b want 20/1", f_pc, f_valid); end
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL flush_noissue: got %b want 0", imem_en); end
    cyc(); update = 2'b01; #1;
    vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL flush_bubble: got %b want 0", f_valid); end
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 14'h8) begin miscompares++; $display("FAIL flush_refetch: got %b/%h want 1/8", imem_en, imem_addr); end
    cyc(); #1;
    vectors++; if (f_pc !== 32'h20 || f_valid !== 1'b1) begin miscompares++; $display("FAIL flush_again: got %h/%b want 20/1", f_pc, f_valid); end
    vectors++; if (f_inst !== 32'hBEEF_0020) begin miscompares++; $display("FAIL flush_inst: got %h want beef0020", f_inst); end
  endtask

  task automatic test_halt();
    logic seen;
    cyc(); halt = 1'b1; update = 2'b00; #1;
    vectors++; if (f_pc !== 32'h24) begin miscompares++; $display("FAIL halt_at: got %h want 24", f_pc); end
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      vectors++; if (f_pc !== 32'h24 || f_valid !== 1'b1) begin miscompares++; $display("FAIL halt_hold: got %h/%b want 24/1", f_pc, f_valid); end
      vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL halt_en: got %b want 0", imem_en); end
    end
    halt = 1'b0; update = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      cyc(); #1;
      if (f_valid === 1'b1 && f_pc !== 32'h24) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL halt_resume_timeout: got no new inst want pc 28"); end
    vectors++; if (f_pc !== 32'h28) begin miscompares++; $display("FAIL halt_resume_pc: got %h want 28", f_pc); end
    vectors++; if (f_inst !== 32'hBEEF_0028) begin miscompares++; $display("FAIL halt_resume_inst: got %h want beef0028", f_inst); end
  endtask

  task automatic test_async_reset();
    #1 rst = 1'b1; #1;
    vectors++; if (f_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b want 0", f_valid); end
    vectors++; if (f_inst !== 32'h1 || f_pc !== 32'h0) begin miscompares++; $display("FAIL arst_out: got %h/%h want 1/0", f_inst, f_pc); end
    vectors++; if (imem_en !== 1'b0) begin miscompares++; $display("FAIL arst_en: got %b want 0", imem_en); end
    rst = 1'b0; #1;
    vectors++; if (imem_en !== 1'b1 || imem_addr !== 14'h0) begin miscompares++; $display("FAIL arst_restart: got %b/%h want 1/0", imem_en, imem_addr); end
    cyc(); #1;
    vectors++; if (f_pc !== 32'h0 || f_valid !== 1'b1) begin miscompares++; $display("FAIL arst_first: got %h/%b want 0/1", f_pc, f_valid); end
    vectors++; if (f_inst !== 32'hBEEF_0000) begin miscompares++; $display("FAIL arst_inst: got %h want beef0000", f_inst); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_redirect_vs_advance();
    test_flush();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
